// File: rtl/pet_button_ctrl_if.sv
// Board push-button pins (raw, active-low) and the cleaned pet command signals.
`timescale 1ns/1ps
interface pet_button_ctrl_if;
    logic btn_comer_n;
    logic btn_jugar_n;
    logic btn_descansar_n;
    logic btn_test_n;
    logic btn_accel_n;
    logic comer;
    logic jugar;
    logic descansar;
    logic test;
    logic acelerar;

    // master drives the pins and consumes commands; slave is the controller
    modport master (
        output btn_comer_n, btn_jugar_n, btn_descansar_n, btn_test_n, btn_accel_n,
        input  comer, jugar, descansar, test, acelerar
    );
    modport slave (
        input  btn_comer_n, btn_jugar_n, btn_descansar_n, btn_test_n, btn_accel_n,
        output comer, jugar, descansar, test, acelerar
    );
endinterface

// File: rtl/pet_button_ctrl.sv
// Sync + debounce five pet buttons into arbitrated action pulses and test/acelerar levels;
// press-to-pulse latency DEB_CYCLES+3, no backpressure. PET_AUTOREPEAT_EN adds action auto-repeat.
`timescale 1ns/1ps
module pet_button_ctrl #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned HOLD_CYCLES   = 250000000,
    parameter int unsigned REPEAT_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    pet_button_ctrl_if.slave btn
);

    localparam int NB       = 5;
    localparam int CH_TEST  = 3;
    localparam int CH_ACCEL = 4;
    localparam int DW       = $clog2(DEB_CYCLES + 1);
    localparam int HW       = $clog2(HOLD_CYCLES + 1);

    if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("pet_button_ctrl: DEB_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDING = 2'd1,
        FIRED   = 2'd2
    } hold_state_e;

    logic [NB-1:0] raw_n;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] deb_q, deb_d;
    logic [NB-1:0] deb_prev_q;
    logic [DW-1:0] deb_cnt_q [NB];
    logic [DW-1:0] deb_cnt_d [NB];
    logic [NB-1:0] press;

    logic [2:0]    pend_q, pend_d;
    logic [2:0]    set_req;
    logic [2:0]    grant;
    logic [2:0]    act_q;

    hold_state_e   hold_state_q, hold_state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          test_q, test_d;
    logic          acel_q, acel_d;

    assign raw_n = {btn.btn_accel_n, btn.btn_test_n, btn.btn_descansar_n,
                    btn.btn_jugar_n, btn.btn_comer_n};

    // Debounced value only follows the synced one after DEB_CYCLES unbroken disagreeing cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw_n;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign press = deb_prev_q & ~deb_q;

`ifdef PET_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RW-1:0] rep_cnt_q [3];
    logic [RW-1:0] rep_cnt_d [3];

    // Phase counter is zero on the press-edge cycle and every REPEAT_CYCLES after while held.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            set_req[i]   = press[i] | (~deb_q[i] & (rep_cnt_q[i] == '0));
            rep_cnt_d[i] = '0;
            if (!deb_q[i] && rep_cnt_q[i] != RW'(REPEAT_CYCLES - 1)) begin
                rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end
`else
    assign set_req = press[2:0];
`endif

    // Fixed priority comer > jugar > descansar; losers stay pending for later cycles.
    always_comb begin
        grant = '0;
        if (pend_q[0]) begin
            grant = 3'b001;
        end else if (pend_q[1]) begin
            grant = 3'b010;
        end else if (pend_q[2]) begin
            grant = 3'b100;
        end
        pend_d = (pend_q & ~grant) | set_req;
    end

    always_comb begin
        hold_state_d = hold_state_q;
        hold_cnt_d   = hold_cnt_q;
        test_d       = test_q;
        acel_d       = acel_q ^ press[CH_ACCEL];
        case (hold_state_q)
            IDLE: begin
                if (press[CH_TEST]) begin
                    hold_state_d = HOLDING;
                    hold_cnt_d   = '0;
                end
            end
            HOLDING: begin
                if (deb_q[CH_TEST]) begin
                    hold_state_d = IDLE;
                end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                    test_d       = ~test_q;
                    hold_state_d = FIRED;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            FIRED: begin
                if (deb_q[CH_TEST]) begin
                    hold_state_d = IDLE;
                end
            end
            default: begin
                hold_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            act_q        <= '0;
            hold_state_q <= IDLE;
            hold_cnt_q   <= '0;
            test_q       <= 1'b0;
            acel_q       <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            act_q        <= grant;
            hold_state_q <= hold_state_d;
            hold_cnt_q   <= hold_cnt_d;
            test_q       <= test_d;
            acel_q       <= acel_d;
        end
    end

    assign btn.comer     = act_q[0];
    assign btn.jugar     = act_q[1];
    assign btn.descansar = act_q[2];
    assign btn.test      = test_q;
    assign btn.acelerar  = acel_q;

endmodule

// File: tb/tb_pet_button_ctrl.sv
// Bench for pet_button_ctrl: table vectors, directed corner sequences and random stimulus vs a timeline model.
`timescale 1ns/1ps
module tb_pet_button_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] press_m = 5'b11111;   // active-high: {accel, test, desc, jugar, comer}

    always #5 clk = ~clk;

    pet_button_ctrl_if bus();

    assign bus.btn_comer_n     = ~press_m[0];
    assign bus.btn_jugar_n     = ~press_m[1];
    assign bus.btn_descansar_n = ~press_m[2];
    assign bus.btn_test_n      = ~press_m[3];
    assign bus.btn_accel_n     = ~press_m[4];

    pet_button_ctrl #(
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference timeline: t counts rising edges since reset release.
    int         t;
    logic [4:0] m_s1, m_s2, m_deb;
    logic [4:0] m_hist[$];            // last DEB synchronised samples, oldest first
    int         m_hs[5];              // edge at which the debounced press began, -1 if released
    logic [2:0] m_pend, m_act;
    logic       m_test, m_acel;

    int pulse_cnt[3];
    int first_edge[3];

    typedef struct {
        logic [4:0] mask;
        int         hold;
        int         n_comer;
        int         n_jugar;
        int         n_desc;
        logic       test_lvl;
        logic       acel_lvl;
    } vec_t;

    vec_t vecs[9];

    function automatic int rep(input int held);
`ifdef PET_AUTOREPEAT_EN
        return (held - 1) / RPT + 1;
`else
        return (held > 0) ? 1 : 0;
`endif
    endfunction

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, t, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        m_s1   = '1;
        m_s2   = '1;
        m_deb  = '1;
        m_pend = '0;
        m_act  = '0;
        m_test = 1'b0;
        m_acel = 1'b0;
        m_hist.delete();
        for (int k = 0; k < DEB; k++) m_hist.push_back(5'b11111);
        for (int c = 0; c < 5; c++) m_hs[c] = -1;
    endtask

    task automatic model_edge(input logic [4:0] raw_n);
        logic [2:0] g;
        logic [2:0] add;
        bit         stable;
        t++;
        g   = '0;
        add = '0;
        for (int i = 0; i < 3; i++) if (m_pend[i] && g == 3'b000) g[i] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (m_hs[c] >= 0) begin
`ifdef PET_AUTOREPEAT_EN
                if ((t - 1 - m_hs[c]) % RPT == 0) add[c] = 1'b1;
`else
                if (t - 1 == m_hs[c]) add[c] = 1'b1;
`endif
            end
        end
        m_act  = g;
        m_pend = (m_pend & ~g) | add;
        if (m_hs[3] >= 0 && t == m_hs[3] + HOLD + 1) m_test = ~m_test;
        if (m_hs[4] >= 0 && t - 1 == m_hs[4]) m_acel = ~m_acel;
        m_hist.push_back(m_s2);
        void'(m_hist.pop_front());
        for (int c = 0; c < 5; c++) begin
            stable = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][c] == m_deb[c]) stable = 1'b0;
            if (stable) begin
                m_deb[c] = ~m_deb[c];
                m_hs[c]  = m_deb[c] ? -1 : t;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw_n;
    endtask

    task automatic clr_rec();
        for (int i = 0; i < 3; i++) begin
            pulse_cnt[i]  = 0;
            first_edge[i] = -1;
        end
    endtask

    task automatic tick();
        logic [2:0] act;
        @(posedge clk);
        model_edge(~press_m);
        #1;
        act = {bus.descansar, bus.jugar, bus.comer};
        check("comer", bus.comer, m_act[0]);
        check("jugar", bus.jugar, m_act[1]);
        check("descansar", bus.descansar, m_act[2]);
        check("test", bus.test, m_test);
        check("acelerar", bus.acelerar, m_acel);
        check("action_onehot", ($countones(act) <= 1), 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (act[i]) begin
                pulse_cnt[i]++;
                if (first_edge[i] < 0) first_edge[i] = t;
            end
        end
    endtask

    task automatic do_reset(input logic [4:0] mask);
        @(negedge clk);
        press_m = mask;
        rst     = 1'b1;
        #1;
        check("rst_comer", bus.comer, 1'b0);
        check("rst_jugar", bus.jugar, 1'b0);
        check("rst_descansar", bus.descansar, 1'b0);
        check("rst_test", bus.test, 1'b0);
        check("rst_acelerar", bus.acelerar, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clr_rec();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ts;
        logic [4:0] mask;
        logic [4:0] cur;
        int dur;

        vecs[0] = '{5'b00010, 30, 0, rep(30), 0, 1'b0, 1'b0};
        vecs[1] = '{5'b01000, 10, 0, 0, 0, 1'b0, 1'b0};
        vecs[2] = '{5'b01000, 40, 0, 0, 0, 1'b1, 1'b0};
        vecs[3] = '{5'b01000, 40, 0, 0, 0, 1'b0, 1'b0};
        vecs[4] = '{5'b10000, 10, 0, 0, 0, 1'b0, 1'b1};
        vecs[5] = '{5'b10000, 10, 0, 0, 0, 1'b0, 1'b0};
        vecs[6] = '{5'b01001, 40, rep(40), 0, 0, 1'b1, 1'b0};
        vecs[7] = '{5'b00100, 3, 0, 0, 0, 1'b1, 1'b0};
        vecs[8] = '{5'b00100, 4, 0, 0, rep(4), 1'b1, 1'b0};

        model_reset();
        clr_rec();

        // Reset with every button held: one priority-ordered burst after 2+DEB+1 quiet edges.
        do_reset(5'b11111);
        repeat (12) tick();
        check_int("rst_first_comer_edge", first_edge[0], DEB + 4);
        check_int("rst_first_jugar_edge", first_edge[1], DEB + 5);
        check_int("rst_first_desc_edge", first_edge[2], DEB + 6);
        press_m = '0;
        repeat (40) tick();

        // Clean comer press first sampled at edge 10.
        do_reset(5'b00000);
        while (t < 9) tick();
        press_m = 5'b00001;
        repeat (50) tick();
        press_m = '0;
        repeat (20) tick();
        check_int("clean_comer_edge", first_edge[0], 10 + DEB + 3);
        check_int("clean_comer_count", pulse_cnt[0], rep(50));
        check_int("clean_jugar_count", pulse_cnt[1], 0);
        check_int("clean_desc_count", pulse_cnt[2], 0);

        // Bouncy comer press, then stable low.
        clr_rec();
        for (int i = 0; i < 12; i++) begin
            press_m = ((i / 2) % 2 == 0) ? 5'b00001 : 5'b00000;
            tick();
        end
        press_m = 5'b00001;
        ts = t + 1;
        repeat (30) tick();
        press_m = '0;
        repeat (20) tick();
        check_int("bouncy_comer_edge", first_edge[0], ts + DEB + 3);
        check_int("bouncy_comer_count", pulse_cnt[0], rep(30));

        // Three action buttons in the same cycle.
        clr_rec();
        press_m = 5'b00111;
        ts = t + 1;
        repeat (8) tick();
        press_m = '0;
        repeat (20) tick();
        check_int("simul_comer_edge", first_edge[0], ts + DEB + 3);
        check_int("simul_jugar_edge", first_edge[1], ts + DEB + 4);
        check_int("simul_desc_edge", first_edge[2], ts + DEB + 5);
        check_int("simul_comer_count", pulse_cnt[0], 1);
        check_int("simul_jugar_count", pulse_cnt[1], 1);
        check_int("simul_desc_count", pulse_cnt[2], 1);

        // Table of hold vectors applied from a fresh reset.
        do_reset(5'b00000);
        for (int i = 0; i < 9; i++) begin
            clr_rec();
            press_m = vecs[i].mask;
            repeat (vecs[i].hold) tick();
            press_m = '0;
            repeat (30) tick();
            check_int($sformatf("vec%0d_comer_count", i), pulse_cnt[0], vecs[i].n_comer);
            check_int($sformatf("vec%0d_jugar_count", i), pulse_cnt[1], vecs[i].n_jugar);
            check_int($sformatf("vec%0d_desc_count", i), pulse_cnt[2], vecs[i].n_desc);
            check($sformatf("vec%0d_test", i), bus.test, vecs[i].test_lvl);
            check($sformatf("vec%0d_acelerar", i), bus.acelerar, vecs[i].acel_lvl);
        end

        // Random held patterns with bounces, and one asynchronous reset mid-stream.
        for (int s = 0; s < 50; s++) begin
            if (s == 25) do_reset(press_m);
            mask = 5'($urandom_range(0, 31));
            dur  = $urandom_range(1, 40);
            for (int d = 0; d < dur; d++) begin
                cur = mask;
                if ($urandom_range(0, 7) == 0) cur[$urandom_range(0, 4)] ^= 1'b1;
                press_m = cur;
                tick();
            end
        end
        press_m = '0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
